key_mode_ctrl: RTL and testbench

Input-side companion to the LED pattern drivers. It samples a raw active-low push button, synchronises and debounces it, and classifies each press as short or long. It also maintains the current LED display mode index that selects which LED mode driver owns `led_out`. It sits between the board key pin and the LED mode multiplexer.

---
 rtl/led_pkg.sv | 21 ++
 rtl/key_mode_ctrl_if.sv | 15 +
 rtl/key_debounce.sv | 42 ++++
 rtl/key_mode_ctrl.sv | 121 ++++++++++++
 tb/tb_key_mode_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and default timing constants for the key/LED mode blocks.
// Long-press support in key_mode_ctrl is built only when KEY_LONG_PRESS_EN is defined.
package led_pkg;
  localparam int unsigned MODE_W           = 3;
  // Defaults assume a 2400-cycle, 1 s period shared with the LED drivers
  localparam int unsigned PERIOD_CYC       = 2400;
  localparam int unsigned DEF_DEBOUNCE_CYC = PERIOD_CYC / 10;
  localparam int unsigned DEF_LONG_CYC     = PERIOD_CYC;
  localparam int unsigned DEF_NUM_MODES    = 4;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_PRESSED = 2'd1,
    KS_LONG    = 2'd2
  } key_state_e;

  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m,
                                                  input int unsigned       n);
    return (m == MODE_W'(n - 1)) ? '0 : m + 1'b1;
  endfunction
endpackage

// File: rtl/key_mode_ctrl_if.sv
// Key pin in, debounced level / press strobes / mode index out.
interface key_mode_ctrl_if;
  import led_pkg::*;
  logic              key_n;
  logic              key_level;
  logic              press_pulse;
  logic              long_pulse;
  logic [MODE_W-1:0] mode;
  logic              mode_chg;

  modport slave  (input  key_n,
                  output key_level, press_pulse, long_pulse, mode, mode_chg);
  modport master (output key_n,
                  input  key_level, press_pulse, long_pulse, mode, mode_chg);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce counter for an active-low board key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 240
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic key_level_o
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);

  logic [1:0]    sync_q;
  logic          key_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  assign key_s = ~sync_q[1];

  // Any cycle agreeing with the current level restarts the count
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (key_s != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) level_d = key_s;
      else                                 cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign key_level_o = level_q;
endmodule

// File: rtl/key_mode_ctrl.sv
// Key press classifier and LED mode index register.
// Define KEY_LONG_PRESS_EN to build long-press detection (LONG state, hold counter).
module key_mode_ctrl
  import led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
  parameter int unsigned NUM_MODES    = DEF_NUM_MODES
) (
  input  logic            clk,
  input  logic            rst_n,
  key_mode_ctrl_if.slave  bus
);
  if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC || NUM_MODES < 1 || NUM_MODES > 8) begin : g_cfg_err
    $error("key_mode_ctrl: illegal parameter set");
  end

  key_state_e        state_q, state_d;
  logic              lvl_prev_q;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              press_q, press_d;
  logic              chg_q, chg_d;
  logic              rise, fall;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n_i     (bus.key_n),
    .key_level_o (bus.key_level)
  );

  assign rise = bus.key_level & ~lvl_prev_q;
  assign fall = ~bus.key_level & lvl_prev_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYC) + 1;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    press_d = 1'b0;
    chg_d   = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    hold_d  = hold_q;
    long_d  = 1'b0;
`endif
    case (state_q)
      KS_IDLE: if (rise) begin
        press_d = 1'b1;
        state_d = KS_PRESSED;
`ifdef KEY_LONG_PRESS_EN
        hold_d  = '0;
`endif
      end
      KS_PRESSED: begin
`ifdef KEY_LONG_PRESS_EN
        hold_d = hold_q + 1'b1;
`endif
        // Release takes priority over reaching the long threshold
        if (fall) begin
          mode_d  = next_mode(mode_q, NUM_MODES);
          chg_d   = 1'b1;
          state_d = KS_IDLE;
        end
`ifdef KEY_LONG_PRESS_EN
        else if (hold_q == HW'(LONG_CYC)) begin
          long_d  = 1'b1;
          mode_d  = '0;
          chg_d   = 1'b1;
          state_d = KS_LONG;
        end
`endif
      end
`ifdef KEY_LONG_PRESS_EN
      KS_LONG: begin
        hold_d = hold_q;
        if (fall) state_d = KS_IDLE;
      end
`endif
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= KS_IDLE;
      lvl_prev_q <= 1'b0;
      mode_q     <= '0;
      press_q    <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_prev_q <= bus.key_level;
      mode_q     <= mode_d;
      press_q    <= press_d;
      chg_q      <= chg_d;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end
  assign bus.long_pulse = long_q;
`else
  assign bus.long_pulse = 1'b0;
`endif

  assign bus.press_pulse = press_q;
  assign bus.mode_chg    = chg_q;
  assign bus.mode        = mode_q;
endmodule

// File: tb/tb_key_mode_ctrl.sv
// Randomized key stimulus checked against a time-window reference model via an event scoreboard.
module tb_key_mode_ctrl;
  localparam int D = 4;
  localparam int L = 16;
  localparam int N = 4;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_mode_ctrl_if kif();

  key_mode_ctrl #(.DEBOUNCE_CYC(D), .LONG_CYC(L), .NUM_MODES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif)
  );

  typedef struct {
    int cyc;
    bit pp;
    bit lp;
    bit mc;
    int md;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;
  int  n_chk = 0, n_pass = 0;
  int  cyc = 0;
  bit  raw_q[$];
  bit  m_lvl = 0, m_prv = 0, rose, fell, all_mis;
  int  m_mode = 0;
  bit  pressing = 0, long_done = 0;
  int  pstart = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: level flips once the synchronised key has disagreed with it for D
  // consecutive samples; press/release/long events derive from absolute edge times.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        raw_q.delete();
        for (int i = 0; i < D + 2; i++) raw_q.push_back(1'b1);
        cyc = 0; m_lvl = 0; m_prv = 0; m_mode = 0;
        pressing = 0; long_done = 0; exp_q.delete();
      end else begin
        cyc++;
        raw_q.push_back(kif.key_n);
        void'(raw_q.pop_front());
        all_mis = 1'b1;
        for (int i = 0; i < D; i++) if (raw_q[i] != m_lvl) all_mis = 1'b0;
        rose  = m_lvl & ~m_prv;
        fell  = ~m_lvl & m_prv;
        m_prv = m_lvl;
        if (all_mis) m_lvl = ~m_lvl;
        if (rose) begin
          exp_q.push_back('{cyc, 1'b1, 1'b0, 1'b0, m_mode});
          pressing = 1; long_done = 0; pstart = cyc;
        end else if (pressing && fell) begin
          if (!long_done) begin
            m_mode = (m_mode + 1) % N;
            exp_q.push_back('{cyc, 1'b0, 1'b0, 1'b1, m_mode});
          end
          pressing = 0; long_done = 0;
        end else if (LONG_EN && pressing && !long_done && cyc == pstart + L + 1) begin
          m_mode = 0;
          exp_q.push_back('{cyc, 1'b0, 1'b1, 1'b1, 0});
          long_done = 1;
        end
      end
    end
  end

  // Monitor: pop one expected event whenever the DUT strobes anything
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("key_level", int'(kif.key_level), int'(m_lvl));
        if (kif.press_pulse || kif.long_pulse || kif.mode_chg) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", int'({kif.press_pulse, kif.long_pulse, kif.mode_chg}), 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("press_pulse", int'(kif.press_pulse), int'(e.pp));
            chk("long_pulse", int'(kif.long_pulse), int'(e.lp));
            chk("mode_chg", int'(kif.mode_chg), int'(e.mc));
            chk("event_mode", int'(kif.mode), e.md);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          chk("missing_event_cycle", cyc, e.cyc);
        end
        chk("mode", int'(kif.mode), m_mode);
      end
    end
  end

  task automatic drive(input bit v, input int n);
    kif.key_n = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    kif.key_n = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key_level", int'(kif.key_level), 0);
    chk("rst_press_pulse", int'(kif.press_pulse), 0);
    chk("rst_long_pulse", int'(kif.long_pulse), 0);
    chk("rst_mode_chg", int'(kif.mode_chg), 0);
    chk("rst_mode", int'(kif.mode), 0);
    rst_n = 1'b1;
    drive(1, 5);
    // Short glitch, clean press, wrap, long press, bounce
    drive(0, 3);  drive(1, 20);
    drive(0, 10); drive(1, 20);
    repeat (4) begin drive(0, 10); drive(1, 12); end
    drive(0, 10); drive(1, 12);
    drive(0, 40); drive(1, 20);
    repeat (5) begin drive(0, 2); drive(1, 2); end
    drive(0, 20); drive(1, 20);
    // Sweep hold times across the long threshold, including a same-cycle release
    for (int h = 12; h <= 24; h++) begin drive(0, h); drive(1, 15); end
    // Random presses with occasional sub-debounce glitches
    repeat (60) begin
      drive(0, $urandom_range(1, 35));
      if ($urandom_range(0, 3) == 0) begin drive(1, $urandom_range(1, 3)); drive(0, $urandom_range(1, 10)); end
      drive(1, $urandom_range(1, 25));
    end
    drive(1, 30);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
